// File: rtl/cmd_queue_sched.sv
// Command-queue front end: round-robin write arbitration between fetch and host,
// paced reads toward DECODE, occupancy tracking and a flush/recover sequence.
module cmd_queue_sched #(
  parameter int unsigned DATA_W = 30,
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned CNT_W  = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              f_valid,
  input  logic [DATA_W-1:0] f_data,
  output logic              f_ready,
  input  logic              h_valid,
  input  logic [DATA_W-1:0] h_data,
  output logic              h_ready,
  input  logic              flush,
  input  logic              dec_ready,
  output logic              q_write,
  output logic [DATA_W-1:0] q_data,
  output logic              q_read,
  output logic              q_clear,
  output logic              dec_valid,
  output logic [CNT_W-1:0]  count,
  output logic              full,
  output logic              empty
);

  typedef enum logic [1:0] {
    RUN,
    FLUSH,
    RECOVER
  } state_e;

  typedef enum logic {
    GRANT_FETCH,
    GRANT_HOST
  } grant_e;

  state_e              state;
  grant_e              last_grant;
  logic [CNT_W-1:0]    count_r;
  logic                q_write_r;
  logic [DATA_W-1:0]   q_data_r;
  logic                q_clear_r;
  logic                dec_pending;

  logic                accept_ok;
  logic                f_win;
  logic                h_win;
  logic                f_hs;
  logic                h_hs;
  logic                wr_hs;
  logic                rd;

  always_comb begin
    accept_ok = (state == RUN) && !flush && (count_r < CNT_W'(DEPTH));
    // On a tie the requester that did not win last time gets the slot.
    f_win     = f_valid && (!h_valid || (last_grant == GRANT_HOST));
    h_win     = h_valid && (!f_valid || (last_grant == GRANT_FETCH));
    f_hs      = accept_ok && f_win;
    h_hs      = accept_ok && h_win;
    wr_hs     = f_hs || h_hs;
    // A write still in flight is counted but not yet in the queue, so it cannot be popped.
    rd        = (state == RUN) && !flush && dec_ready && (count_r > CNT_W'(q_write_r));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= RUN;
      last_grant  <= GRANT_HOST;
      count_r     <= '0;
      q_write_r   <= 1'b0;
      q_data_r    <= '0;
      q_clear_r   <= 1'b0;
      dec_pending <= 1'b0;
    end else begin
      q_write_r   <= wr_hs;
      q_clear_r   <= flush;
      dec_pending <= rd;

      if (wr_hs) begin
        q_data_r   <= f_hs ? f_data : h_data;
        last_grant <= f_hs ? GRANT_FETCH : GRANT_HOST;
      end

      if (flush) begin
        count_r <= '0;
      end else if (wr_hs && !rd) begin
        count_r <= count_r + CNT_W'(1);
      end else if (!wr_hs && rd) begin
        count_r <= count_r - CNT_W'(1);
      end

      case (state)
        RUN:     state <= flush ? FLUSH : RUN;
        FLUSH:   state <= flush ? FLUSH : RECOVER;
        RECOVER: state <= flush ? FLUSH : RUN;
        default: state <= RUN;
      endcase
    end
  end

  assign f_ready   = f_hs;
  assign h_ready   = h_hs;
  assign q_write   = q_write_r;
  assign q_data    = q_data_r;
  assign q_read    = rd;
  assign q_clear   = q_clear_r;
  assign dec_valid = dec_pending && (state == RUN) && !flush;
  assign count     = count_r;
  assign full      = (count_r == CNT_W'(DEPTH));
  assign empty     = (count_r == '0);

endmodule

// File: tb/tb_cmd_queue_sched.sv
// Directed bench for cmd_queue_sched: inputs driven on the falling edge,
// outputs checked 1 ns later, i.e. mid-cycle and away from the rising edge.
module tb_cmd_queue_sched;

  localparam int unsigned DATA_W = 30;
  localparam int unsigned DEPTH  = 16;
  localparam int unsigned CNT_W  = 5;

  localparam logic [DATA_W-1:0] FD  = 30'h0F0F0F0F;
  localparam logic [DATA_W-1:0] HD  = 30'h12345678;
  localparam logic [DATA_W-1:0] FD2 = 30'h05A5A5A5;
  localparam logic [DATA_W-1:0] FD3 = 30'h2AAAAAAA;
  localparam logic [DATA_W-1:0] FD4 = 30'h01234567;

  logic              clk;
  logic              reset;
  logic              f_valid;
  logic [DATA_W-1:0] f_data;
  logic              f_ready;
  logic              h_valid;
  logic [DATA_W-1:0] h_data;
  logic              h_ready;
  logic              flush;
  logic              dec_ready;
  logic              q_write;
  logic [DATA_W-1:0] q_data;
  logic              q_read;
  logic              q_clear;
  logic              dec_valid;
  logic [CNT_W-1:0]  count;
  logic              full;
  logic              empty;

  int unsigned n_cmp;
  int unsigned n_err;

  cmd_queue_sched #(
    .DATA_W(DATA_W),
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .f_valid  (f_valid),
    .f_data   (f_data),
    .f_ready  (f_ready),
    .h_valid  (h_valid),
    .h_data   (h_data),
    .h_ready  (h_ready),
    .flush    (flush),
    .dec_ready(dec_ready),
    .q_write  (q_write),
    .q_data   (q_data),
    .q_read   (q_read),
    .q_clear  (q_clear),
    .dec_valid(dec_valid),
    .count    (count),
    .full     (full),
    .empty    (empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    reset = 1'b1; flush = 1'b0; dec_ready = 1'b0;
    f_valid = 1'b0; h_valid = 1'b0; f_data = '0; h_data = '0;
    @(negedge clk);
    @(negedge clk);
    #1;
    n_cmp++; if (q_write !== 1'b0) begin n_err++; $display("FAIL reset_q_write got %b exp 0", q_write); end
    n_cmp++; if (q_data !== '0) begin n_err++; $display("FAIL reset_q_data got %h exp 0", q_data); end
    n_cmp++; if (q_clear !== 1'b0) begin n_err++; $display("FAIL reset_q_clear got %b exp 0", q_clear); end
    n_cmp++; if (dec_valid !== 1'b0) begin n_err++; $display("FAIL reset_dec_valid got %b exp 0", dec_valid); end
    n_cmp++; if (count !== 5'd0) begin n_err++; $display("FAIL reset_count got %0d exp 0", count); end
    n_cmp++; if (full !== 1'b0) begin n_err++; $display("FAIL reset_full got %b exp 0", full); end
    n_cmp++; if (empty !== 1'b1) begin n_err++; $display("FAIL reset_empty got %b exp 1", empty); end
    reset = 1'b0;
  endtask

  // Both producers always valid, no reads: grants alternate F,H,... until full.
  task automatic test_fill_alternate();
    for (int i = 0; i < 18; i++) begin
      int idx;
      logic [DATA_W-1:0] exp_qd;
      @(negedge clk);
      f_valid = 1'b1; h_valid = 1'b1; dec_ready = 1'b0; f_data = FD; h_data = HD;
      #1;
      idx = (i > 16) ? 16 : i;
      exp_qd = (idx == 0) ? '0 : ((((idx - 1) % 2) == 0) ? FD : HD);
      n_cmp++; if (count !== CNT_W'(idx)) begin n_err++; $display("FAIL fill_count[%0d] got %0d exp %0d", i, count, idx); end
      n_cmp++; if (f_ready !== ((i < 16) && (i % 2 == 0))) begin n_err++; $display("FAIL fill_f_ready[%0d] got %b", i, f_ready); end
      n_cmp++; if (h_ready !== ((i < 16) && (i % 2 == 1))) begin n_err++; $display("FAIL fill_h_ready[%0d] got %b", i, h_ready); end
      n_cmp++; if (q_write !== ((i >= 1) && (i <= 16))) begin n_err++; $display("FAIL fill_q_write[%0d] got %b", i, q_write); end
      n_cmp++; if (q_data !== exp_qd) begin n_err++; $display("FAIL fill_q_data[%0d] got %h exp %h", i, q_data, exp_qd); end
      n_cmp++; if (full !== (i >= 16)) begin n_err++; $display("FAIL fill_full[%0d] got %b", i, full); end
      n_cmp++; if (empty !== (i == 0)) begin n_err++; $display("FAIL fill_empty[%0d] got %b", i, empty); end
      n_cmp++; if (q_read !== 1'b0) begin n_err++; $display("FAIL fill_q_read[%0d] got %b exp 0", i, q_read); end
    end
  endtask

  // From full: pop frees a slot only for the following cycle, then drain to empty.
  task automatic test_drain_full();
    int unsigned k;
    @(negedge clk);
    f_valid = 1'b1; h_valid = 1'b0; dec_ready = 1'b1; f_data = FD2;
    #1;
    n_cmp++; if (count !== 5'd16) begin n_err++; $display("FAIL drain_count0 got %0d exp 16", count); end
    n_cmp++; if (q_read !== 1'b1) begin n_err++; $display("FAIL drain_q_read0 got %b exp 1", q_read); end
    n_cmp++; if (f_ready !== 1'b0) begin n_err++; $display("FAIL drain_f_ready0 got %b exp 0", f_ready); end
    @(negedge clk);
    #1;
    n_cmp++; if (count !== 5'd15) begin n_err++; $display("FAIL drain_count1 got %0d exp 15", count); end
    n_cmp++; if (f_ready !== 1'b1) begin n_err++; $display("FAIL drain_f_ready1 got %b exp 1", f_ready); end
    n_cmp++; if (dec_valid !== 1'b1) begin n_err++; $display("FAIL drain_dec_valid1 got %b exp 1", dec_valid); end
    @(negedge clk);
    f_valid = 1'b0;
    #1;
    n_cmp++; if (count !== 5'd15) begin n_err++; $display("FAIL drain_count2 got %0d exp 15", count); end
    n_cmp++; if ((q_write !== 1'b1) || (q_data !== FD2)) begin n_err++; $display("FAIL drain_write2 got %b/%h exp 1/%h", q_write, q_data, FD2); end
    k = 0;
    while ((empty !== 1'b1) && (k < 40)) begin
      @(negedge clk);
      #1;
      k++;
    end
    n_cmp++; if ((empty !== 1'b1) || (count !== 5'd0)) begin n_err++; $display("FAIL drain_empty got empty=%b count=%0d exp 1/0 after %0d cycles", empty, count, k); end
    n_cmp++; if (dec_valid !== 1'b1) begin n_err++; $display("FAIL drain_last_dec_valid got %b exp 1", dec_valid); end
    dec_ready = 1'b0;
  endtask

  // Single push into an empty queue with DECODE ready: write, pop, valid in successive cycles.
  task automatic test_single_latency();
    @(negedge clk);
    f_valid = 1'b1; h_valid = 1'b0; dec_ready = 1'b1; f_data = FD3;
    #1;
    n_cmp++; if ((f_ready !== 1'b1) || (q_read !== 1'b0)) begin n_err++; $display("FAIL lat_t got f_ready=%b q_read=%b exp 1/0", f_ready, q_read); end
    @(negedge clk);
    f_valid = 1'b0;
    #1;
    n_cmp++; if ((q_write !== 1'b1) || (q_data !== FD3)) begin n_err++; $display("FAIL lat_t1_write got %b/%h exp 1/%h", q_write, q_data, FD3); end
    n_cmp++; if ((q_read !== 1'b0) || (count !== 5'd1)) begin n_err++; $display("FAIL lat_t1_read got q_read=%b count=%0d exp 0/1", q_read, count); end
    @(negedge clk);
    #1;
    n_cmp++; if ((q_read !== 1'b1) || (dec_valid !== 1'b0) || (q_write !== 1'b0)) begin n_err++; $display("FAIL lat_t2 got q_read=%b dec_valid=%b q_write=%b exp 1/0/0", q_read, dec_valid, q_write); end
    @(negedge clk);
    #1;
    n_cmp++; if ((dec_valid !== 1'b1) || (q_read !== 1'b0)) begin n_err++; $display("FAIL lat_t3 got dec_valid=%b q_read=%b exp 1/0", dec_valid, q_read); end
    n_cmp++; if ((count !== 5'd0) || (empty !== 1'b1)) begin n_err++; $display("FAIL lat_t3_count got %0d/%b exp 0/1", count, empty); end
    dec_ready = 1'b0;
  endtask

  // Fill to 8, simultaneous push/pop, drain to 5, then a one-cycle flush.
  task automatic test_same_cycle_and_flush();
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      f_valid = 1'b1; h_valid = 1'b0; dec_ready = 1'b0; f_data = FD4;
      #1;
      n_cmp++; if ((count !== CNT_W'(i)) || (f_ready !== 1'b1)) begin n_err++; $display("FAIL push8[%0d] got count=%0d f_ready=%b exp %0d/1", i, count, f_ready, i); end
    end
    @(negedge clk);
    dec_ready = 1'b1;
    #1;
    n_cmp++; if ((count !== 5'd8) || (f_ready !== 1'b1) || (q_read !== 1'b1)) begin n_err++; $display("FAIL both8 got count=%0d f_ready=%b q_read=%b exp 8/1/1", count, f_ready, q_read); end
    @(negedge clk);
    f_valid = 1'b0;
    #1;
    n_cmp++; if ((count !== 5'd8) || (empty !== 1'b0) || (full !== 1'b0)) begin n_err++; $display("FAIL hold8 got count=%0d empty=%b full=%b exp 8/0/0", count, empty, full); end
    n_cmp++; if ((q_write !== 1'b1) || (q_read !== 1'b1) || (dec_valid !== 1'b1)) begin n_err++; $display("FAIL hold8_strobes got %b%b%b exp 111", q_write, q_read, dec_valid); end
    @(negedge clk);
    #1;
    n_cmp++; if (count !== 5'd7) begin n_err++; $display("FAIL pop7 got %0d exp 7", count); end
    @(negedge clk);
    #1;
    n_cmp++; if (count !== 5'd6) begin n_err++; $display("FAIL pop6 got %0d exp 6", count); end
    // Flush cycle: a read result from the previous cycle must be suppressed.
    @(negedge clk);
    flush = 1'b1; h_valid = 1'b1; h_data = HD; dec_ready = 1'b1;
    #1;
    n_cmp++; if (count !== 5'd5) begin n_err++; $display("FAIL flush0_count got %0d exp 5", count); end
    n_cmp++; if ((h_ready !== 1'b0) || (q_read !== 1'b0) || (dec_valid !== 1'b0)) begin n_err++; $display("FAIL flush0 got h_ready=%b q_read=%b dec_valid=%b exp 000", h_ready, q_read, dec_valid); end
    n_cmp++; if (q_clear !== 1'b0) begin n_err++; $display("FAIL flush0_q_clear got %b exp 0", q_clear); end
    @(negedge clk);
    flush = 1'b0;
    #1;
    n_cmp++; if ((q_clear !== 1'b1) || (count !== 5'd0)) begin n_err++; $display("FAIL flush1 got q_clear=%b count=%0d exp 1/0", q_clear, count); end
    n_cmp++; if ((h_ready !== 1'b0) || (q_read !== 1'b0) || (dec_valid !== 1'b0) || (q_write !== 1'b0)) begin n_err++; $display("FAIL flush1_block got %b%b%b%b exp 0000", h_ready, q_read, dec_valid, q_write); end
    @(negedge clk);
    #1;
    n_cmp++; if ((q_clear !== 1'b0) || (h_ready !== 1'b0) || (dec_valid !== 1'b0) || (count !== 5'd0)) begin n_err++; $display("FAIL recover got q_clear=%b h_ready=%b dec_valid=%b count=%0d exp 0/0/0/0", q_clear, h_ready, dec_valid, count); end
    @(negedge clk);
    #1;
    n_cmp++; if ((h_ready !== 1'b1) || (q_clear !== 1'b0)) begin n_err++; $display("FAIL resume got h_ready=%b q_clear=%b exp 1/0", h_ready, q_clear); end
    @(negedge clk);
    h_valid = 1'b0; dec_ready = 1'b0;
    #1;
    n_cmp++; if ((count !== 5'd1) || (q_write !== 1'b1) || (q_data !== HD)) begin n_err++; $display("FAIL resume_write got count=%0d q_write=%b q_data=%h exp 1/1/%h", count, q_write, q_data, HD); end
  endtask

  // Reset (together with flush) during FLUSH restores RUN and host-as-last-grant.
  task automatic test_reset_mid_flush();
    @(negedge clk);
    f_valid = 1'b1; h_valid = 1'b0; dec_ready = 1'b0; f_data = FD2;
    #1;
    n_cmp++; if (f_ready !== 1'b1) begin n_err++; $display("FAIL rmf_push got f_ready=%b exp 1", f_ready); end
    @(negedge clk);
    f_valid = 1'b0; flush = 1'b1;
    #1;
    @(negedge clk);
    reset = 1'b1;
    #1;
    n_cmp++; if (q_clear !== 1'b1) begin n_err++; $display("FAIL rmf_in_flush got q_clear=%b exp 1", q_clear); end
    @(negedge clk);
    reset = 1'b0; flush = 1'b0; f_valid = 1'b1; h_valid = 1'b1; f_data = FD; h_data = HD;
    #1;
    n_cmp++; if ((q_clear !== 1'b0) || (count !== 5'd0) || (empty !== 1'b1) || (q_write !== 1'b0)) begin n_err++; $display("FAIL rmf_after got q_clear=%b count=%0d empty=%b q_write=%b exp 0/0/1/0", q_clear, count, empty, q_write); end
    n_cmp++; if ((f_ready !== 1'b1) || (h_ready !== 1'b0)) begin n_err++; $display("FAIL rmf_tie got f_ready=%b h_ready=%b exp 1/0", f_ready, h_ready); end
    @(negedge clk);
    #1;
    n_cmp++; if ((f_ready !== 1'b0) || (h_ready !== 1'b1)) begin n_err++; $display("FAIL rmf_tie2 got f_ready=%b h_ready=%b exp 0/1", f_ready, h_ready); end
    n_cmp++; if ((q_write !== 1'b1) || (q_data !== FD) || (count !== 5'd1)) begin n_err++; $display("FAIL rmf_write got %b/%h/%0d exp 1/%h/1", q_write, q_data, count, FD); end
    @(negedge clk);
    f_valid = 1'b0; h_valid = 1'b0;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    test_reset();
    test_fill_alternate();
    test_drain_full();
    test_single_latency();
    test_same_cycle_and_flush();
    test_reset_mid_flush();
    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
